// File: rtl/spi_reg_ctrl.sv
// Register-access controller behind spi_slave: decodes framed read/write commands
// and runs single-beat request/ack transfers on the internal register bus.
module spi_reg_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ssel,
    input  logic [7:0]        cmd,
    input  logic              cmd_valid,
    output logic [7:0]        response,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WDATA = 3'd2,
        S_WBUS  = 3'd3,
        S_RBUS  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_d;
    logic [2:0]        ssel_sync;
    logic              frame, frame_q, frame_rise;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ai_q, ai_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [7:0]        resp_q, resp_d;
    logic              err_to_q, err_to_d;
    logic              err_ov_q, err_ov_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              hold_valid_q, hold_valid_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              xfer_done;

    // Same tap depth as spi_slave so the last byte strobe of a frame precedes frame falling.
    assign frame      = ~ssel_sync[1];
    assign frame_q    = ~ssel_sync[2];
    assign frame_rise = frame & ~frame_q;

    // Bus handshake: a request (bus_we or bus_re) rises one cycle after its trigger and
    // holds addr/wdata stable; bus_ack sampled in any request cycle completes it and the
    // request drops on the next edge. With no ack, it drops after TIMEOUT cycles high.
    assign xfer_done = bus_ack || (cnt_q == TMO_LAST);

    always_comb begin
        state_d      = state;
        addr_d       = addr_q;
        ai_d         = ai_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        re_d         = re_q;
        resp_d       = resp_q;
        err_to_d     = err_to_q;
        err_ov_d     = err_ov_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;

        case (state)
            S_IDLE: begin
                if (frame_rise) state_d = S_CMD;
            end
            S_CMD: begin
                if (!frame) begin
                    state_d = S_IDLE;
                end else if (cmd_valid) begin
                    addr_d = cmd[ADDR_W-1:0];
                    ai_d   = cmd[6];
                    if (cmd[7]) begin
                        state_d = S_WDATA;
                    end else begin
                        re_d    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_RBUS;
                    end
                end
            end
            S_WDATA: begin
                if (!frame) begin
                    state_d = S_IDLE;
                end else if (hold_valid_q) begin
                    // Buffered byte goes out first; a byte arriving now refills the freed slot.
                    wdata_d      = hold_data_q;
                    we_d         = 1'b1;
                    cnt_d        = 8'd0;
                    hold_valid_d = 1'b0;
                    state_d      = S_WBUS;
                    if (cmd_valid) begin
                        hold_data_d  = cmd;
                        hold_valid_d = 1'b1;
                    end
                end else if (cmd_valid) begin
                    wdata_d = cmd;
                    we_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_WBUS;
                end
            end
            S_WBUS: begin
                if (cmd_valid) begin
                    if (hold_valid_q) begin
                        err_ov_d = 1'b1;
                    end else begin
                        hold_data_d  = cmd;
                        hold_valid_d = 1'b1;
                    end
                end
                if (xfer_done) begin
                    we_d = 1'b0;
                    if (!bus_ack) err_to_d = 1'b1;
                    if (ai_q) addr_d = addr_q + ADDR_W'(1);
                    state_d = frame ? S_WDATA : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RBUS: begin
                if (xfer_done) begin
                    re_d   = 1'b0;
                    resp_d = bus_ack ? bus_rdata : 8'hFF;
                    if (!bus_ack) err_to_d = 1'b1;
                    state_d = frame ? S_DRAIN : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (!frame) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A byte still pending when the frame closes belongs to no transfer.
        if (!frame) hold_valid_d = 1'b0;

        busy_d = (state_d == S_WDATA) || (state_d == S_WBUS) ||
                 (state_d == S_RBUS)  || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ssel_sync    <= 3'b111;
            addr_q       <= '0;
            ai_q         <= 1'b0;
            wdata_q      <= 8'h00;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            resp_q       <= 8'h00;
            err_to_q     <= 1'b0;
            err_ov_q     <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_valid_q <= 1'b0;
            cnt_q        <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_d;
            ssel_sync    <= {ssel_sync[1:0], ssel};
            addr_q       <= addr_d;
            ai_q         <= ai_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            re_q         <= re_d;
            resp_q       <= resp_d;
            err_to_q     <= err_to_d;
            err_ov_q     <= err_ov_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign response    = resp_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_we      = we_q;
    assign bus_re      = re_q;
    assign busy        = busy_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: drives framed command bytes, answers the register bus,
// and scores every write request against an expected queue.
module tb_spi_reg_ctrl;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ssel = 1'b1;
    logic [7:0]        cmd = 8'h00;
    logic              cmd_valid = 1'b0;
    logic [7:0]        response;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [7:0]        bus_rdata = 8'h00;
    logic              bus_ack = 1'b0;
    logic              busy;
    logic              err_timeout;
    logic              err_overrun;

    spi_reg_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ssel(ssel), .cmd(cmd), .cmd_valid(cmd_valid),
        .response(response), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] mon_exp;
    logic [ADDR_W+7:0] cur_wr;
    logic [ADDR_W-1:0] cur_raddr;
    int   wr_count = 0;
    int   we_len = 0, re_len = 0;
    int   last_we_len = 0, last_re_len = 0;
    logic we_prev = 1'b0, re_prev = 1'b0;

    bit   ack_en = 1'b1;
    int   ack_lat = 0;
    int   req_cyc = 0;
    bit   force_ack = 1'b0;
    logic ack_now;

    // Register-bus responder: ack in request cycle ack_lat (0 = first cycle).
    always @(negedge clk) begin
        ack_now = 1'b0;
        if (bus_we || bus_re) begin
            if (ack_en && req_cyc == ack_lat) ack_now = 1'b1;
            req_cyc++;
        end else begin
            req_cyc = 0;
        end
        bus_ack = ack_now | force_ack;
    end

    // Write scoreboard and request-length / stability monitor.
    always @(negedge clk) begin
        if (bus_we) begin
            if (!we_prev) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h, no write expected", bus_addr, bus_wdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({bus_addr, bus_wdata} !== mon_exp) begin
                        errors++;
                        $display("FAIL write_data: got addr/data=%0h required %0h", {bus_addr, bus_wdata}, mon_exp);
                    end
                end
                cur_wr = {bus_addr, bus_wdata};
                we_len = 1;
            end else begin
                checks++;
                if ({bus_addr, bus_wdata} !== cur_wr) begin
                    errors++;
                    $display("FAIL write_stable: got %0h required %0h", {bus_addr, bus_wdata}, cur_wr);
                end
                we_len++;
            end
        end else if (we_prev) begin
            last_we_len = we_len;
        end
        we_prev = bus_we;

        if (bus_re) begin
            if (!re_prev) begin
                cur_raddr = bus_addr;
                re_len = 1;
            end else begin
                checks++;
                if (bus_addr !== cur_raddr) begin
                    errors++;
                    $display("FAIL read_addr_stable: got %0h required %0h", bus_addr, cur_raddr);
                end
                re_len++;
            end
        end else if (re_prev) begin
            last_re_len = re_len;
        end
        re_prev = bus_re;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        cmd = b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        ssel = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        ssel = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit rd, input logic lvl, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (((rd ? bus_re : bus_we) !== lvl) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((rd ? bus_re : bus_we) !== lvl) begin
            errors++;
            $display("FAIL %s: request still %b after %0d cycles, required %b", tag, rd ? bus_re : bus_we, n, lvl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({response, bus_addr, bus_wdata, bus_we, bus_re, busy, err_timeout, err_overrun} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {response, bus_addr, bus_wdata, bus_we, bus_re, busy, err_timeout, err_overrun});
        end
        rst_n = 1'b1;
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({response, bus_we, bus_re, busy, err_timeout, err_overrun} !== 13'd0) begin
            errors++;
            $display("FAIL stray_ack: got %0h required 0", {response, bus_we, bus_re, busy, err_timeout, err_overrun});
        end
    endtask

    task automatic test_write_noai();
        int n0;
        n0 = wr_count;
        ack_en = 1'b1;
        ack_lat = 2;
        exp_q.push_back({6'd5, 8'hAA});
        start_frame();
        send_byte(8'h85);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_wdata: got %b required 1", busy);
        end
        send_byte(8'hAA);
        wait_req(1'b0, 1'b1, 10, "noai_rise");
        wait_req(1'b0, 1'b0, 20, "noai_fall");
        #1;
        checks++;
        if (last_we_len !== 3) begin
            errors++;
            $display("FAIL noai_len: got %0d required 3", last_we_len);
        end
        end_frame();
        checks++;
        if ((wr_count - n0) !== 1) begin
            errors++;
            $display("FAIL noai_count: got %0d required 1", wr_count - n0);
        end
        checks++;
        if ({busy, err_timeout, err_overrun} !== 3'b000) begin
            errors++;
            $display("FAIL noai_idle: got %b required 000", {busy, err_timeout, err_overrun});
        end
    endtask

    task automatic test_write_ai_wrap();
        ack_lat = 0;
        exp_q.push_back({6'd63, 8'h11});
        exp_q.push_back({6'd0, 8'h22});
        start_frame();
        send_byte(8'hFF);
        send_byte(8'h11);
        wait_req(1'b0, 1'b0, 20, "ai_fall1");
        send_byte(8'h22);
        wait_req(1'b0, 1'b0, 20, "ai_fall2");
        #1;
        checks++;
        if (last_we_len !== 1) begin
            errors++;
            $display("FAIL ai_len: got %0d required 1", last_we_len);
        end
        checks++;
        if (bus_addr !== 6'd1) begin
            errors++;
            $display("FAIL ai_next_addr: got %0d required 1", bus_addr);
        end
        end_frame();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL ai_pending: got %0d writes outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_read();
        bus_rdata = 8'h5A;
        ack_lat = 3;
        start_frame();
        send_byte(8'h12);
        wait_req(1'b1, 1'b1, 10, "rd_rise");
        checks++;
        if (bus_addr !== 6'h12 || response !== 8'h00) begin
            errors++;
            $display("FAIL rd_start: got addr=%0h resp=%0h required addr=12 resp=00", bus_addr, response);
        end
        wait_req(1'b1, 1'b0, 20, "rd_fall");
        #1;
        checks++;
        if (response !== 8'h5A || last_re_len !== 4) begin
            errors++;
            $display("FAIL rd_result: got resp=%0h len=%0d required resp=5a len=4", response, last_re_len);
        end
        send_byte(8'h99);
        send_byte(8'h80);
        checks++;
        if ({bus_re, bus_we, busy, err_overrun} !== 4'b0010 || response !== 8'h5A) begin
            errors++;
            $display("FAIL rd_drain: got re/we/busy/ov=%b resp=%0h required 0010 resp=5a",
                     {bus_re, bus_we, busy, err_overrun}, response);
        end
        end_frame();
        start_frame();
        checks++;
        if (response !== 8'h5A || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_next_frame: got resp=%0h busy=%b required resp=5a busy=0", response, busy);
        end
        bus_rdata = 8'h3C;
        ack_lat = 0;
        send_byte(8'h21);
        checks++;
        if (bus_re !== 1'b1 || bus_addr !== 6'h21) begin
            errors++;
            $display("FAIL rd_min_start: got re=%b addr=%0h required re=1 addr=21", bus_re, bus_addr);
        end
        wait_req(1'b1, 1'b0, 20, "rd_min_fall");
        #1;
        checks++;
        if (response !== 8'h3C || last_re_len !== 1) begin
            errors++;
            $display("FAIL rd_min_result: got resp=%0h len=%0d required resp=3c len=1", response, last_re_len);
        end
        end_frame();
    endtask

    task automatic test_timeout();
        bus_rdata = 8'hC3;
        ack_en = 1'b1;
        ack_lat = TIMEOUT - 1;
        start_frame();
        send_byte(8'h04);
        wait_req(1'b1, 1'b0, 40, "last_cycle_fall");
        #1;
        checks++;
        if (response !== 8'hC3 || last_re_len !== TIMEOUT || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL last_cycle_ack: got resp=%0h len=%0d to=%b required resp=c3 len=%0d to=0",
                     response, last_re_len, err_timeout, TIMEOUT);
        end
        end_frame();
        ack_en = 1'b0;
        start_frame();
        send_byte(8'h03);
        checks++;
        if (bus_re !== 1'b1 || bus_addr !== 6'h03) begin
            errors++;
            $display("FAIL tmo_start: got re=%b addr=%0h required re=1 addr=03", bus_re, bus_addr);
        end
        wait_req(1'b1, 1'b0, 40, "tmo_fall");
        #1;
        checks++;
        if (response !== 8'hFF || last_re_len !== TIMEOUT || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_result: got resp=%0h len=%0d to=%b required resp=ff len=%0d to=1",
                     response, last_re_len, err_timeout, TIMEOUT);
        end
        end_frame();
        ack_en = 1'b1;
        ack_lat = 1;
        bus_rdata = 8'h77;
        start_frame();
        send_byte(8'h05);
        wait_req(1'b1, 1'b0, 20, "tmo_after_fall");
        #1;
        checks++;
        if (response !== 8'h77 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: got resp=%0h to=%b required resp=77 to=1", response, err_timeout);
        end
        end_frame();
    endtask

    task automatic test_frame_end();
        int n0;
        n0 = wr_count;
        start_frame();
        send_byte(8'h80);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL fe_busy: got %b required 1", busy);
        end
        end_frame();
        checks++;
        if (busy !== 1'b0 || bus_we !== 1'b0 || wr_count !== n0) begin
            errors++;
            $display("FAIL fe_no_write: got busy=%b we=%b writes=%0d required 0 0 %0d", busy, bus_we, wr_count, n0);
        end
        ack_lat = 8;
        exp_q.push_back({6'd10, 8'h66});
        start_frame();
        send_byte(8'h8A);
        send_byte(8'h66);
        ssel = 1'b1;
        wait_req(1'b0, 1'b0, 30, "fe_wbus_fall");
        #1;
        checks++;
        if (last_we_len !== 9) begin
            errors++;
            $display("FAIL fe_wbus_len: got %0d required 9", last_we_len);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL fe_wbus_idle: got busy=%b we=%b required 0 0", busy, bus_we);
        end
    endtask

    task automatic test_overrun();
        int n0;
        n0 = wr_count;
        ack_lat = 10;
        exp_q.push_back({6'd7, 8'h01});
        exp_q.push_back({6'd7, 8'h02});
        start_frame();
        send_byte(8'h87);
        send_byte(8'h01);
        send_byte(8'h02);
        checks++;
        if (err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL ov_buffered: got %b required 0", err_overrun);
        end
        send_byte(8'h03);
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ov_flag: got %b required 1", err_overrun);
        end
        wait_req(1'b0, 1'b0, 30, "ov_fall1");
        wait_req(1'b0, 1'b1, 10, "ov_rise2");
        wait_req(1'b0, 1'b0, 30, "ov_fall2");
        repeat (20) @(posedge clk);
        end_frame();
        checks++;
        if ((wr_count - n0) !== 2 || exp_q.size() !== 0 || err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL ov_result: got writes=%0d pending=%0d ov=%b required 2 0 1",
                     wr_count - n0, exp_q.size(), err_overrun);
        end
    endtask

    task automatic test_reset_mid();
        ack_en = 1'b0;
        exp_q.push_back({6'd1, 8'h55});
        start_frame();
        send_byte(8'h81);
        send_byte(8'h55);
        wait_req(1'b0, 1'b1, 10, "rm_rise");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({response, bus_addr, bus_wdata, bus_we, bus_re, busy, err_timeout, err_overrun} !== 27'd0) begin
            errors++;
            $display("FAIL reset_mid: got %0h required 0",
                     {response, bus_addr, bus_wdata, bus_we, bus_re, busy, err_timeout, err_overrun});
        end
        ssel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack_en = 1'b1;
        ack_lat = 1;
        exp_q.push_back({6'd2, 8'h99});
        start_frame();
        send_byte(8'h82);
        send_byte(8'h99);
        wait_req(1'b0, 1'b0, 20, "rm_after_fall");
        #1;
        checks++;
        if (last_we_len !== 2) begin
            errors++;
            $display("FAIL rm_after_len: got %0d required 2", last_we_len);
        end
        end_frame();
        checks++;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_after_done: got pending=%0d busy=%b required 0 0", exp_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_noai();
        test_write_ai_wrap();
        test_read();
        test_timeout();
        test_frame_end();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before test sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
